// File: rtl/arb_requester.sv
// Requester-side client for a round-robin arbiter port: requests, streams an incrementing burst while granted, releases.
// Optional grant-wait timeout is built when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] base,
    input  logic              gnt,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              done,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remain;
    logic [LEN_W-1:0]  remain_nxt;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              req_nxt;
    logic              busy_nxt;
    logic              valid_nxt;
    logic              done_nxt;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             timeout_nxt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        word_nxt   = word;
        data_nxt   = data_out;
        req_nxt    = req;
        busy_nxt   = busy;
        valid_nxt  = 1'b0;
        done_nxt   = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt  = WAIT;
                    remain_nxt = len;
                    word_nxt   = base;
                    req_nxt    = 1'b1;
                    busy_nxt   = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end
            WAIT, XFER: begin
                if (gnt) begin
                    data_nxt   = word;
                    valid_nxt  = 1'b1;
                    word_nxt   = word + DATA_W'(1);
                    remain_nxt = remain - LEN_W'(1);
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                    // Last word releases the request in the same edge so the arbiter can rotate
                    if (remain == LEN_W'(1)) begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = XFER;
                    end
                end
`ifdef ARB_REQ_TIMEOUT_EN
                else if (state == WAIT) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    if (wait_cnt_nxt == CNT_W'(TIMEOUT)) begin
                        state_nxt    = IDLE;
                        req_nxt      = 1'b0;
                        busy_nxt     = 1'b0;
                        timeout_nxt  = 1'b1;
                        remain_nxt   = '0;
                        wait_cnt_nxt = '0;
                    end
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            remain     <= '0;
            word       <= '0;
            data_out   <= '0;
            req        <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            remain     <= remain_nxt;
            word       <= word_nxt;
            data_out   <= data_nxt;
            req        <= req_nxt;
            busy       <= busy_nxt;
            data_valid <= valid_nxt;
            done       <= done_nxt;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end
`endif

endmodule
